rx_frame_loader: RTL
====================

// Module: rx_frame_loader
// PURPOSE
//  Sequences the serial receiver: consumes bytes delivered by the RX block (pronto pulse + data),
//  parses a framed image upload, writes pixels into the frame buffer and, on a valid frame,
//  starts the Sobel pipeline and holds off new uploads until the pipeline reports done.
//  Frame format: SYNC, W (1..255), H (1..255), W*H pixel bytes in row-major order, then CK.
//  CK = XOR of all pixel bytes.
// PARAMETERS
//  SYNC_BYTE  8'hA5    frame start marker
//  ADDR_W     16       frame-buffer address width; W*H must be <= 2**ADDR_W
//  TIMEOUT    500000   max clock cycles between bytes inside a frame before abort
// PORTS
//  clock       in   1       system clock
//  reset       in   1       asynchronous, active-high
//  rx_pronto   in   1       1-cycle pulse: rx_dado valid (from serial receiver)
//  rx_dado     in   8       received byte
//  rx_erro     in   1       parity/stop error, qualified by rx_pronto
//  proc_done   in   1       1-cycle pulse from Sobel pipeline: processing finished
//  mem_we      out  1       frame-buffer write enable (1 cycle per pixel)
//  mem_addr    out  ADDR_W  write address
//  mem_data    out  8       write data
//  img_w       out  8       latched width of the last accepted header
//  img_h       out  8       latched height of the last accepted header
//  start_proc  out  1       1-cycle pulse: frame valid, start pipeline
//  frame_err   out  1       1-cycle pulse: frame aborted
//  busy        out  1       high in every state except IDLE
//  db_estado   out  4       debug state code
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE; all outputs, counter, checksum and timer = 0.
//  - FSM (db_estado code):
//    IDLE(0)    byte==SYNC_BYTE -> GET_W; other bytes ignored.
//    GET_W(1)   byte -> latch img_w; ->GET_H.
//    GET_H(2)   byte -> latch img_h; ->CHECK.
//    CHECK(3)   one cycle: W==0, H==0 or W*H>2**ADDR_W -> ERROR; else clear cnt/ck -> LOAD.
//    LOAD(4)    each byte: next cycle mem_we=1, mem_addr=cnt, mem_data=byte; ck^=byte; cnt++.
//               The byte written at cnt==W*H-1 moves the FSM to GET_CK.
//    GET_CK(5)  byte==ck -> START; else ERROR.
//    START(6)   start_proc=1 for exactly one cycle -> WAIT_PROC.
//    WAIT_PROC(7) bytes dropped (no writes); proc_done -> IDLE.
//    ERROR(E)   frame_err=1 for exactly one cycle -> IDLE.
//  - W*H computed as 16-bit product; compare width max(16, ADDR_W+1) to avoid overflow.
//  - Timer: cleared on every rx_pronto and on entry to GET_W; counts in GET_W, GET_H, LOAD, GET_CK.
//    Reaching TIMEOUT -> ERROR. rx_pronto in the same cycle as expiry: byte wins, timer clears.
//  - rx_pronto with rx_erro=1: ERROR in GET_W/GET_H/LOAD/GET_CK; ignored in IDLE and WAIT_PROC.
//  - A byte arriving during CHECK/START/ERROR is dropped (at most 1-cycle windows; RX byte period is
//    far longer).
//  - Latency: pixel byte pronto -> mem_we 1 cycle. CK byte pronto -> START next cycle.
//    start_proc is asserted 2 cycles after CK pronto.
//  - proc_done outside WAIT_PROC is ignored. Async reset mid-frame aborts silently:
//    no frame_err, no further writes.
//  - img_w/img_h hold their values through ERROR until the next header overwrites them.
// STRUCTURE
//  - Shared package: state encodings (4-bit codes above), SYNC_BYTE default, frame-format constants.
//  - Single module: FSM, pixel counter, XOR accumulator, timeout counter ($clog2(TIMEOUT+1) bits).
//    No sub-module needed.
// TESTING
//  1 SYNC,W=2,H=2,px 10 20 30 40,CK=40 -> writes addr0..3=10,20,30,40; one start_proc; img_w=2,img_h=2.
//  2 Same frame but CK=41 -> 4 writes, frame_err pulse, no start_proc; FSM returns to IDLE (db 0).
//  3 SYNC,W=0 or (ADDR_W=4, W=5,H=4) -> frame_err from CHECK; zero writes.
//  4 TIMEOUT=100: SYNC,W=3,H=1, one pixel, then 101 idle cycles -> frame_err; a following good frame
//    is accepted.
//  5 After a good frame, send SYNC + bytes before proc_done -> no writes, busy=1; after proc_done,
//    a new frame loads.
//  6 Assert reset during LOAD at cnt=2 -> all outputs 0 next cycle, db_estado=0, no frame_err;
//    rx_erro with a pixel byte -> frame_err.

Source files
------------

// File: rtl/rx_frame_loader_pkg.sv
// Shared state codes and frame-format constants for the serial image-upload loader.
package rx_frame_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'h0,
    ST_GET_W     = 4'h1,
    ST_GET_H     = 4'h2,
    ST_CHECK     = 4'h3,
    ST_LOAD      = 4'h4,
    ST_GET_CK    = 4'h5,
    ST_START     = 4'h6,
    ST_WAIT_PROC = 4'h7,
    ST_ERROR     = 4'hE
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned ADDR_W_DEFAULT    = 16;
  localparam int unsigned TIMEOUT_DEFAULT   = 500000;
  localparam int unsigned DIM_W             = 8;
  localparam int unsigned PROD_W            = 2 * DIM_W;

  // W*H must be compared against 2**ADDR_W without either side overflowing.
  function automatic int unsigned cmp_width(input int unsigned addr_w);
    return (addr_w + 1 > PROD_W) ? addr_w + 1 : PROD_W;
  endfunction

  function automatic logic is_timed_state(input state_e s);
    return (s == ST_GET_W) || (s == ST_GET_H) || (s == ST_LOAD) || (s == ST_GET_CK);
  endfunction

endpackage

// File: rtl/rx_frame_loader.sv
// Parses SYNC/W/H/pixels/CK frames from the serial receiver, fills the frame buffer
// and kicks the Sobel pipeline once a frame checks out.
module rx_frame_loader
  import rx_frame_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_pronto,
  input  logic [7:0]        rx_dado,
  input  logic              rx_erro,
  input  logic              proc_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic [7:0]        img_w,
  output logic [7:0]        img_h,
  output logic              start_proc,
  output logic              frame_err,
  output logic              busy,
  output logic [3:0]        db_estado
);

  localparam int unsigned       CMP_W       = cmp_width(ADDR_W);
  localparam int unsigned       TMR_W       = $clog2(TIMEOUT + 1);
  localparam logic [CMP_W-1:0]  MAX_PIXELS  = CMP_W'(1) << ADDR_W;
  localparam logic [TMR_W-1:0]  TIMEOUT_VAL = TMR_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [7:0]          img_w_q, img_h_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [7:0]          ck_q;
  logic [TMR_W-1:0]    timer_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_data_q;
  logic                start_proc_q;
  logic                frame_err_q;
  logic                busy_q;
  logic [3:0]          db_estado_q;

  logic                byte_ok;
  logic                byte_bad;
  logic                timed;
  logic                expired;
  logic [PROD_W-1:0]   prod;
  logic [PROD_W-1:0]   last_px;
  logic                dims_bad;
  logic                at_last_px;

  assign byte_ok  = rx_pronto & ~rx_erro;
  assign byte_bad = rx_pronto & rx_erro;
  assign timed    = is_timed_state(state_q);
  // An arriving byte beats a timer that expires in the same cycle.
  assign expired  = timed & ~rx_pronto & (timer_q == TIMEOUT_VAL);

  assign prod       = PROD_W'(img_w_q) * PROD_W'(img_h_q);
  assign last_px    = prod - PROD_W'(1);
  assign dims_bad   = (img_w_q == 8'd0) || (img_h_q == 8'd0) || (CMP_W'(prod) > MAX_PIXELS);
  assign at_last_px = (CMP_W'(cnt_q) == CMP_W'(last_px));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (byte_ok && (rx_dado == SYNC_BYTE)) state_d = ST_GET_W;
      end
      ST_GET_W: begin
        if (byte_bad || expired) state_d = ST_ERROR;
        else if (byte_ok)        state_d = ST_GET_H;
      end
      ST_GET_H: begin
        if (byte_bad || expired) state_d = ST_ERROR;
        else if (byte_ok)        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = dims_bad ? ST_ERROR : ST_LOAD;
      end
      ST_LOAD: begin
        if (byte_bad || expired)     state_d = ST_ERROR;
        else if (byte_ok && at_last_px) state_d = ST_GET_CK;
      end
      ST_GET_CK: begin
        if (byte_bad || expired) state_d = ST_ERROR;
        else if (byte_ok)        state_d = (rx_dado == ck_q) ? ST_START : ST_ERROR;
      end
      ST_START:     state_d = ST_WAIT_PROC;
      ST_WAIT_PROC: begin
        if (proc_done) state_d = ST_IDLE;
      end
      ST_ERROR:     state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      img_w_q      <= 8'd0;
      img_h_q      <= 8'd0;
      cnt_q        <= '0;
      ck_q         <= 8'd0;
      timer_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= 8'd0;
      start_proc_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      db_estado_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != ST_IDLE);
      db_estado_q  <= state_d;
      start_proc_q <= (state_q == ST_START);
      frame_err_q  <= (state_q == ST_ERROR);
      mem_we_q     <= 1'b0;
      timer_q      <= (rx_pronto || !timed) ? '0 : timer_q + TMR_W'(1);

      unique case (state_q)
        ST_GET_W: begin
          if (byte_ok) img_w_q <= rx_dado;
        end
        ST_GET_H: begin
          if (byte_ok) img_h_q <= rx_dado;
        end
        ST_CHECK: begin
          cnt_q <= '0;
          ck_q  <= 8'd0;
        end
        ST_LOAD: begin
          if (byte_ok) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= cnt_q;
            mem_data_q <= rx_dado;
            ck_q       <= ck_q ^ rx_dado;
            cnt_q      <= cnt_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign img_w      = img_w_q;
  assign img_h      = img_h_q;
  assign start_proc = start_proc_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
  assign db_estado  = db_estado_q;

endmodule
